dsp_pipe_arbiter: RTL and testbench

- Shares one 3-stage pipelined add-multiply-and datapath, `out = ((d + a) * b) & c` truncated to WIDTH, among NREQ requesters.
- Round-robin arbitration issues at most one operation per cycle, II=1.
- Each result is tagged with its requester ID through the pipeline.
- A flush/drain state machine quiesces the unit before reconfiguration or a clock gate.
- Sits between requester front-ends and the DSP-mapped datapath.

---
 rtl/dsp_pipe_arbiter.sv | 138 +++++++++++++
 tb/tb_dsp_pipe_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_arbiter.sv
// Round-robin issue of ((d+a)*b)&c from NREQ requesters into one shared pipe at II=1. Results appear 3 cycles after grant.
// There is no backpressure; flush drains the pipe to HALT. DSP_ARB_ISSUE_CNT_EN adds issue_cnt/cnt_clr.
module dsp_pipe_arbiter #(
   parameter int WIDTH = 9,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   input  logic [NREQ*WIDTH-1:0] c_in,
   input  logic [NREQ*WIDTH-1:0] d_in,
   output logic [NREQ-1:0]       gnt,
   input  logic                  flush,
`ifdef DSP_ARB_ISSUE_CNT_EN
   input  logic                  cnt_clr,
   output logic [31:0]           issue_cnt,
`endif
   output logic                  idle,
   output logic                  res_valid,
   output logic [IDW-1:0]        res_id,
   output logic [WIDTH-1:0]      result
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   win_idx;
   logic             win_found;
   logic             issue;

   logic [WIDTH-1:0] a_arr [NREQ];
   logic [WIDTH-1:0] b_arr [NREQ];
   logic [WIDTH-1:0] c_arr [NREQ];
   logic [WIDTH-1:0] d_arr [NREQ];
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] op_dat;

   logic             s0_vld, s1_vld;
   logic [IDW-1:0]   s0_id, s1_id;
   logic [WIDTH-1:0] s0_dat, s1_dat;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = a_in[g*WIDTH +: WIDTH];
      assign b_arr[g] = b_in[g*WIDTH +: WIDTH];
      assign c_arr[g] = c_in[g*WIDTH +: WIDTH];
      assign d_arr[g] = d_in[g*WIDTH +: WIDTH];
   end

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (win_found && state == ST_RUN && !rst)
         gnt[win_idx] = 1'b1;
   end

   assign issue  = |gnt;
   assign sum    = d_arr[win_idx] + a_arr[win_idx];
   assign prod   = sum * b_arr[win_idx];
   assign op_dat = prod & c_arr[win_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_vld    <= 1'b0;
         s0_id     <= '0;
         s0_dat    <= '0;
         s1_vld    <= 1'b0;
         s1_id     <= '0;
         s1_dat    <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         result    <= '0;
         ptr       <= IDW'(NREQ - 1);
      end else begin
         s0_vld    <= issue;
         s0_id     <= win_idx;
         s0_dat    <= op_dat;
         s1_vld    <= s0_vld;
         s1_id     <= s0_id;
         s1_dat    <= s0_dat;
         res_valid <= s1_vld;
         // Output register only loads real ops so result/res_id hold across bubbles.
         if (s1_vld) begin
            res_id <= s1_id;
            result <= s1_dat;
         end
         if (issue)
            ptr <= win_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:   if (flush) state <= ST_DRAIN;
            // The last stage empties on this edge, so the pipe is clear once s0/s1 are.
            ST_DRAIN: if (!s0_vld && !s1_vld) state <= ST_HALT;
            ST_HALT:  if (!flush) state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

   assign idle = (state == ST_HALT) ||
                 (state == ST_RUN && !s0_vld && !s1_vld && !res_valid && !flush);

`ifdef DSP_ARB_ISSUE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         issue_cnt <= '0;
      else if (cnt_clr)
         issue_cnt <= '0;
      else if (issue)
         issue_cnt <= issue_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_dsp_pipe_arbiter.sv
// Randomized and directed bench for dsp_pipe_arbiter against a cycle-indexed reference model.
module tb_dsp_pipe_arbiter;
   localparam int WIDTH = 9;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in, b_in, c_in, d_in;
   logic [NREQ-1:0]       gnt;
   logic                  flush;
   logic                  idle;
   logic                  res_valid;
   logic [IDW-1:0]        res_id;
   logic [WIDTH-1:0]      result;
`ifdef DSP_ARB_ISSUE_CNT_EN
   logic                  cnt_clr;
   logic [31:0]           issue_cnt;
`endif

   always #5 clk = ~clk;

   dsp_pipe_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .c_in      (c_in),
      .d_in      (d_in),
      .gnt       (gnt),
      .flush     (flush),
`ifdef DSP_ARB_ISSUE_CNT_EN
      .cnt_clr   (cnt_clr),
      .issue_cnt (issue_cnt),
`endif
      .idle      (idle),
      .res_valid (res_valid),
      .res_id    (res_id),
      .result    (result)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: results keyed by the cycle they must appear in.
   int     cyc;
   int     ptr_m;
   bit     draining, halted;
   int     due_res [int];
   int     due_id  [int];
   int     last_res, last_id;
   longint cnt_m;
   int     last_w;
   logic [NREQ-1:0] obs_gnt;
   logic   obs_vld, obs_idle;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int ref_op(input int a, input int b, input int c, input int d);
      return (((d + a) * b) % (1 << WIDTH)) & c;
   endfunction

   function automatic int opnd(input logic [NREQ*WIDTH-1:0] bus, input int i);
      return int'(bus[i*WIDTH +: WIDTH]);
   endfunction

   task automatic set_op(input int i, input int a, input int b, input int c, input int d);
      a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
      b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
      c_in[i*WIDTH +: WIDTH] = WIDTH'(c);
      d_in[i*WIDTH +: WIDTH] = WIDTH'(d);
   endtask

   task automatic model_reset();
      due_res.delete();
      due_id.delete();
      ptr_m    = NREQ - 1;
      draining = 0;
      halted   = 0;
      last_res = 0;
      last_id  = 0;
      cnt_m    = 0;
      last_w   = -1;
   endtask

   // One clock cycle: inputs already driven; check at negedge, advance model, return at posedge+1.
   task automatic step();
      int w;
      int exp_v;
      bit busy;
      @(negedge clk);
      w = -1;
      if (!draining && !halted)
         for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (ptr_m + k) % NREQ;
            if (w < 0 && req[j]) w = j;
         end
      obs_gnt  = gnt;
      obs_vld  = res_valid;
      obs_idle = idle;
      check("gnt", gnt, (w >= 0) ? (64'd1 << w) : 64'd0);
      exp_v = 0;
      if (due_res.exists(cyc)) begin
         exp_v    = 1;
         last_res = due_res[cyc];
         last_id  = due_id[cyc];
         due_res.delete(cyc);
         due_id.delete(cyc);
      end
      check("res_valid", res_valid, exp_v);
      check("res_id", res_id, last_id);
      check("result", result, last_res);
      busy = (exp_v == 1) || due_res.exists(cyc + 1) || due_res.exists(cyc + 2);
      check("idle", idle, halted || (!draining && !busy && !flush));
`ifdef DSP_ARB_ISSUE_CNT_EN
      check("issue_cnt", issue_cnt, cnt_m);
`endif
      if (w >= 0) begin
         due_res[cyc + 3] = ref_op(opnd(a_in, w), opnd(b_in, w), opnd(c_in, w), opnd(d_in, w));
         due_id[cyc + 3]  = w;
         ptr_m = w;
         cnt_m = (cnt_m + 1) % (64'd1 << 32);
      end
`ifdef DSP_ARB_ISSUE_CNT_EN
      if (cnt_clr) cnt_m = 0;
`endif
      if (halted) begin
         if (!flush) halted = 0;
      end else if (draining) begin
         if (!due_res.exists(cyc + 1) && !due_res.exists(cyc + 2)) begin
            draining = 0;
            halted   = 1;
         end
      end else if (flush) begin
         draining = 1;
      end
      last_w = w;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      c_in  = '0;
      d_in  = '0;
      flush = 1'b0;
`ifdef DSP_ARB_ISSUE_CNT_EN
      cnt_clr = 1'b0;
`endif
      cyc = 0;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_id", res_id, 0);
      check("rst_result", result, 0);
      check("rst_idle", idle, 1);
      @(posedge clk);
      #1 rst = 1'b0;

      // Round robin from reset: requester 0 first.
      for (int i = 0; i < NREQ; i++) set_op(i, 10*i + 1, 3 + i, 'h1FF, 2*i);
      req = '1;
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_order", obs_gnt, 64'd1 << (k % NREQ));
      end
      req = '0;
      repeat (4) step();

      // Single issue from requester 2.
      set_op(2, 3, 7, 'h1FF, 5);
      req = 4'b0100;
      step();
      check("single_gnt", obs_gnt, 4'b0100);
      req = '0;
      step();
      step();
      check("single_vld", res_valid, 1);
      check("single_id", res_id, 2);
      check("single_res", result, 56);
      step();
      check("single_once", res_valid, 0);
      step();

      // Truncation of sum and product.
      set_op(1, 'h1FF, 'h100, 'h1FF, 'h002);
      req = 4'b0010;
      step();
      set_op(1, 'h1FF, 'h1FF, 'h0F0, 'h002);
      step();
      req = '0;
      step();
      check("trunc_1", result, 'h100);
      step();
      check("trunc_2", result, 'h0F0);
      repeat (3) step();

      // Flush with back-to-back traffic.
      req = '1;
      step();
      step();
      flush = 1'b1;
      step();
      check("flush_issue", obs_gnt != 0, 1);
      step();
      check("flush_gnt_off", obs_gnt, 0);
      step();
      step();
      check("flush_last_vld", obs_vld, 1);
      step();
      check("flush_idle", obs_idle, 1);
      flush = 1'b0;
      step();
      step();
      check("flush_resume", obs_gnt != 0, 1);

      // Async reset with ops in flight.
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check("arst_vld", res_valid, 0);
      check("arst_res", result, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step();
      check("arst_first_gnt", obs_gnt, 4'b0001);
      step();
      step();
      req = '0;
      repeat (4) step();

`ifdef DSP_ARB_ISSUE_CNT_EN
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      req = 4'b0001;
      repeat (5) step();
      check("cnt_before", issue_cnt, 5);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("cnt_after", issue_cnt, 0);
      req = '0;
      repeat (2) step();
`endif

      // Random traffic: requests held until granted, random flush toggling.
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || last_w == i) begin
               req[i] = ($urandom_range(0, 2) != 0);
               set_op(i, $urandom_range(0, 511), $urandom_range(0, 511),
                      $urandom_range(0, 511), $urandom_range(0, 511));
            end
         end
         if ($urandom_range(0, 19) == 0) flush = ~flush;
`ifdef DSP_ARB_ISSUE_CNT_EN
         cnt_clr = ($urandom_range(0, 49) == 0);
`endif
         step();
      end
      req   = '0;
      flush = 1'b0;
`ifdef DSP_ARB_ISSUE_CNT_EN
      cnt_clr = 1'b0;
`endif
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
